// File: rtl/alu_pkg.sv
// Shared definitions for the toy ALU: default datapath width, divider FSM
// encoding and the quotient reported for a zero divisor.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic [ALU_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/subtractor.sv
// Combinational a - b as a + ~b + 1; borrow is the inverted carry out, so it
// is high exactly when b > a (unsigned).
module subtractor #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH:0] sum;

  assign sum    = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
  assign diff   = sum[WIDTH-1:0];
  assign borrow = ~sum[WIDTH];

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock via
// shift-and-trial-subtract, with valid/ready handshakes on both sides.
module restoring_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid never depends on ready and both are plain registers.

  localparam int                ITER_W    = $clog2(WIDTH);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(WIDTH - 1);

  div_state_t        state_q;
  logic [ITER_W-1:0] iter_q;
  logic [WIDTH-1:0]  rem_acc_q;
  logic [WIDTH-1:0]  quo_acc_q;
  logic [WIDTH-1:0]  div_q;
  logic [WIDTH-1:0]  quotient_q;
  logic [WIDTH-1:0]  remainder_q;
  logic              div_by_zero_q;
  logic              out_valid_q;
  logic              in_ready_q;

  logic [WIDTH:0]    shifted_rem;
  logic [WIDTH:0]    trial;
  logic              borrow;
  logic [WIDTH-1:0]  rem_d;
  logic [WIDTH-1:0]  quo_d;
  logic              unused_trial_msb;

  // The next dividend bit enters the remainder from the top of quo_acc.
  assign shifted_rem = {rem_acc_q, quo_acc_q[WIDTH-1]};

  subtractor #(
    .WIDTH(WIDTH + 1)
  ) u_trial_sub (
    .a      (shifted_rem),
    .b      ({1'b0, div_q}),
    .diff   (trial),
    .borrow (borrow)
  );

  // Without borrow the trial is < divisor, so its MSB is always zero.
  assign rem_d            = borrow ? shifted_rem[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_d            = {quo_acc_q[WIDTH-2:0], ~borrow};
  assign unused_trial_msb = trial[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      iter_q        <= '0;
      rem_acc_q     <= '0;
      quo_acc_q     <= '0;
      div_q         <= '0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      out_valid_q   <= 1'b0;
      in_ready_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            if (divisor != '0) begin
              rem_acc_q <= '0;
              quo_acc_q <= dividend;
              div_q     <= divisor;
              iter_q    <= '0;
              state_q   <= RUN;
            end else begin
              quotient_q    <= '1;
              remainder_q   <= dividend;
              div_by_zero_q <= 1'b1;
              out_valid_q   <= 1'b1;
              state_q       <= DONE;
            end
          end
        end

        RUN: begin
          rem_acc_q <= rem_d;
          quo_acc_q <= quo_d;
          iter_q    <= iter_q + ITER_W'(1);
          if (iter_q == LAST_ITER) begin
            quotient_q    <= quo_d;
            remainder_q   <= rem_d;
            div_by_zero_q <= 1'b0;
            out_valid_q   <= 1'b1;
            state_q       <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;
  assign dbg_state   = state_q;

endmodule
